// File: rtl/aes_addroundkey_dr.sv
// aes_addroundkey_dr: dual-rail (WDDL) AddRoundKey stage with precharge, handshake and round counter.
// Optional rail-complementarity checker enabled by defining AES_ARK_RAILCHK_EN.
module aes_addroundkey_dr #(
  parameter int NB = 4,
  parameter int SAT_RND = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            ld_r,
  input  logic [32*NB-1:0] text_in,
  input  logic [32*NB-1:0] text_in_n,
  input  logic [32*NB-1:0] sa_next,
  input  logic [32*NB-1:0] sa_next_n,
  input  logic [32*NB-1:0] w,
  input  logic [32*NB-1:0] w_n,
  output logic [32*NB-1:0] sa,
  output logic [32*NB-1:0] sa_n,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      rnd,
  output logic            rail_err
);
  localparam int W = 32*NB;
  typedef enum logic [1:0] {IDLE, PRE, EVAL_DONE} state_t;
  state_t state, state_nx;
  logic ld_q;
  logic [W-1:0] a, a_n, b, b_n;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == EVAL_DONE;
    state_nx = state == IDLE ? (in_valid ? PRE : IDLE) :
               state == PRE  ? EVAL_DONE :
               (out_ready ? IDLE : EVAL_DONE);
  end
  // Result is formed only from both rails of each operand, never by inverting one rail.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q <= 1'b0;
      a <= '0;
      a_n <= '0;
      b <= '0;
      b_n <= '0;
      sa <= '0;
      sa_n <= '0;
      rnd <= '0;
    end else if (state == IDLE && in_valid) begin
      ld_q <= ld_r;
      a <= ld_r ? text_in : sa_next;
      a_n <= ld_r ? text_in_n : sa_next_n;
      b <= w;
      b_n <= w_n;
      sa <= '0;
      sa_n <= '0;
    end else if (state == PRE) begin
      sa <= (a & b_n) | (a_n & b);
      sa_n <= (a & b) | (a_n & b_n);
      rnd <= ld_q ? 4'd0 : (rnd == 4'(SAT_RND) ? rnd : rnd + 4'd1);
    end
  end
`ifdef AES_ARK_RAILCHK_EN
  logic rail_bad;
  assign rail_bad = (|(a ~^ a_n)) | (|(b ~^ b_n));
  always_ff @(posedge clk)
    if (rst) rail_err <= 1'b0;
    else if (state == PRE && rail_bad) rail_err <= 1'b1;
`else
  assign rail_err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_addroundkey_dr.sv
// tb_aes_addroundkey_dr: scoreboard bench for aes_addroundkey_dr (NB=4, SAT_RND=14).
module tb_aes_addroundkey_dr;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, ld_r, out_valid, out_ready, rail_err;
  logic [127:0] text_in, text_in_n, sa_next, sa_next_n, w, w_n, sa, sa_n;
  logic [3:0] rnd;
  typedef struct {logic [127:0] s; logic [127:0] sn; logic [3:0] r;} exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  logic [3:0] exp_rnd = 4'd0;
  logic exp_err = 1'b0;
  always #5 clk = ~clk;
  aes_addroundkey_dr #(.NB(4), .SAT_RND(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ld_r(ld_r),
    .text_in(text_in), .text_in_n(text_in_n), .sa_next(sa_next), .sa_next_n(sa_next_n),
    .w(w), .w_n(w_n), .sa(sa), .sa_n(sa_n), .out_valid(out_valid), .out_ready(out_ready),
    .rnd(rnd), .rail_err(rail_err)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_op(input logic ld, input logic [127:0] t, input logic [127:0] s,
                        input logic [127:0] k, input logic bad, input int stall);
    exp_t e;
    logic [127:0] x;
    x = (ld ? t : s) ^ k;
    exp_rnd = ld ? 4'd0 : (exp_rnd == 4'd14 ? 4'd14 : exp_rnd + 4'd1);
    e.s = x;
    e.sn = ~x;
    if (bad) begin
      e.s[0] = 1'b0;
      e.sn[0] = 1'b0;
    end
    e.r = exp_rnd;
`ifdef AES_ARK_RAILCHK_EN
    if (bad) exp_err = 1'b1;
`endif
    q.push_back(e);
    in_valid = 1'b1;
    ld_r = ld;
    text_in = t;
    text_in_n = ~t ^ {127'd0, bad};
    sa_next = s;
    sa_next_n = ~s;
    w = k;
    w_n = ~k;
    check("acc_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_sa", sa, 0);
    check("pre_sa_n", sa_n, 0);
    check("pre_ov", out_valid, 0);
    @(posedge clk); #1;
    check("res_ov", out_valid, 1);
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = q.pop_front();
      check("res_sa", sa, e.s);
      check("res_sa_n", sa_n, e.sn);
      check("res_rnd", rnd, e.r);
      check("res_err", rail_err, exp_err);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      ld_r = 1'b1;
      text_in = rnd128();
      text_in_n = ~text_in;
      @(posedge clk); #1;
      check("stall_ov", out_valid, 1);
      check("stall_rdy", in_ready, 0);
      check("stall_sa", sa, e.s);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_rdy", in_ready, 1);
    check("idle_ov", out_valid, 0);
    check("hold_sa", sa, e.s);
    check("hold_sa_n", sa_n, e.sn);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ld_r = 1'b0;
    text_in = '0; text_in_n = '1;
    sa_next = '0; sa_next_n = '1;
    w = '0; w_n = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_sa", sa, 0);
    check("rst_sa_n", sa_n, 0);
    check("rst_rnd", rnd, 0);
    check("rst_err", rail_err, 0);
    rst = 1'b0;
    run_op(1'b1, 128'h00112233445566778899aabbccddeeff, rnd128(),
           128'h000102030405060708090a0b0c0d0e0f, 1'b0, 5);
    check("kat_sa", sa, 128'h00102030405060708090a0b0c0d0e0f0);
    check("kat_sa_n", sa_n, ~128'h00102030405060708090a0b0c0d0e0f0);
    for (int i = 0; i < 16; i++)
      run_op(1'b0, rnd128(), rnd128(), rnd128(), 1'b0, i % 3);
    check("sat_rnd", rnd, 4'd14);
    run_op(1'b1, rnd128() & ~128'd1, rnd128(), rnd128(), 1'b1, 0);
    run_op(1'b0, rnd128(), rnd128(), rnd128(), 1'b0, 1);
    run_op(1'b0, rnd128(), rnd128(), rnd128(), 1'b0, 0);
    in_valid = 1'b1;
    ld_r = 1'b1;
    text_in = rnd128();
    text_in_n = ~text_in;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rnd = 4'd0;
    exp_err = 1'b0;
    check("rpre_rdy", in_ready, 1);
    check("rpre_sa", sa, 0);
    check("rpre_sa_n", sa_n, 0);
    check("rpre_rnd", rnd, 0);
    check("rpre_err", rail_err, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rpre_ov", out_valid, 0);
    end
    run_op(1'b0, rnd128(), rnd128(), rnd128(), 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_addroundkey_dr.md
AES_ADDROUNDKEY_DR -- requirements
Module: aes_addroundkey_dr

Interface
REQ-001 SHALL provide parameter NB, default 4, meaning number of 32-bit state columns (1..8); state width W = 32*NB.
REQ-002 SHALL provide parameter SAT_RND, default 14, meaning round-counter saturation value (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the operand-acceptance handshake.
REQ-006 SHALL have port ld_r  input  1  mode: 1 selects text_in, 0 selects sa_next.
REQ-007 SHALL have ports text_in, text_in_n  input  W  dual-rail plaintext (true and complement rails).
REQ-008 SHALL have ports sa_next, sa_next_n  input  W  dual-rail round-datapath state.
REQ-009 SHALL have ports w, w_n  input  W  dual-rail round key; column c is w[32*(NB-c)-1 -: 32].
REQ-010 SHALL have ports sa, sa_n  output  W  dual-rail registered AddRoundKey result.
REQ-011 SHALL have ports out_valid input-side output 1 and out_ready input 1, the result handshake.
REQ-012 SHALL have port rnd  output  4  rounds completed since last load.
REQ-013 SHALL have port rail_err  output  1  sticky rail-complementarity violation flag.

Function
REQ-014 SHALL implement FSM states IDLE, PRE, EVAL_DONE; in_ready=1 only in IDLE; out_valid=1 only in EVAL_DONE.
REQ-015 IDLE with in_valid=1: at edge, capture ld_r and selected operand/key rails into internal registers, drive sa=sa_n=0 (precharge), go to PRE.
REQ-016 PRE: at next edge, load sa/sa_n with WDDL XOR of captured operands and go to EVAL_DONE; accept-to-out_valid latency is exactly 2 cycles.
REQ-017 WDDL XOR per bit SHALL be sa = (a&b_n)|(a_n&b), sa_n = (a&b)|(a_n&b_n); no single-rail inversion of data.
REQ-018 EVAL_DONE: sa/sa_n and out_valid held stable until out_ready=1; at that edge go to IDLE, sa/sa_n held (no precharge until next accept).
REQ-019 in_valid is ignored outside IDLE; a request presented with out_ready in EVAL_DONE is accepted no earlier than the following IDLE cycle.
REQ-020 rnd: accepted op with ld_r=1 sets rnd=0 at completion; ld_r=0 increments rnd at completion, saturating at SAT_RND.
REQ-021 Byte ordering SHALL be identical across columns: byte 0 of each column at bits [31:24] of that column.

Reset
REQ-022 rst=1 SHALL at the edge force IDLE, sa=sa_n=0, out_valid=0, in_ready=1, rnd=0, rail_err=0, clearing captured operands.
REQ-023 Reset during PRE or EVAL_DONE SHALL discard the in-flight operation with no result or rnd update.

Configuration
REQ-024 Macro AES_ARK_RAILCHK_EN defined: during PRE, any captured bit pair (operand or key) with equal rails sets rail_err at the PRE->EVAL_DONE edge; sticky until rst; result still produced.
REQ-025 Macro AES_ARK_RAILCHK_EN undefined: no check logic; rail_err tied 0.

Verification
REQ-026 NB=4, ld_r=1, text_in=00112233445566778899aabbccddeeff, w=000102030405060708090a0b0c0d0e0f, rails complementary -> out_valid 2 cycles after accept, sa=00102030405060708090a0b0c0d0e0f0, sa_n=~sa, rnd=0.
REQ-027 Accept cycle T -> at T+1 sa=sa_n=0 (all W bits); at T+2 valid result.
REQ-028 out_ready held 0 for 5 cycles in EVAL_DONE, in_valid=1 -> sa, out_valid stable, in_ready=0, no new capture.
REQ-029 Sixteen ld_r=0 ops after one load, SAT_RND=14 -> rnd reads 1..14 then stays 14.
REQ-030 With AES_ARK_RAILCHK_EN, text_in_n bit 0 = text_in bit 0 -> rail_err=1 after op, remains 1 after later clean ops, cleared by rst; without macro rail_err=0.
REQ-031 rst asserted in PRE -> next cycle IDLE, sa=sa_n=0, rnd unchanged from 0 reset value, out_valid never asserted.
